bsk_com_filter: RTL

//  Input conditioning stage directly upstream of the BSK receiver board (PRD) register block.
//  - Takes the raw, active-low command lines from the optocouplers.
//  - Synchronises them to clk and suppresses bounce and glitches with a per-channel

---
 rtl/bsk_com_filter_if.sv | 33 +++
 rtl/bsk_com_filter.sv | 111 +++++++++++
 2 files changed

// File: rtl/bsk_com_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bsk_com_filter_if
//  Description : Command-line bundle between the optocoupler inputs and the
//                BSK command filter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bsk_com_filter_if #(
    parameter int WIDTH = 16
);
    logic             iBl;
    logic [WIDTH-1:0] iComRaw;
    logic [WIDTH-1:0] oCom;
    logic             oChange;
    logic             oTick;

    modport master (
        output iBl,
        output iComRaw,
        input  oCom,
        input  oChange,
        input  oTick
    );

    modport slave (
        input  iBl,
        input  iComRaw,
        output oCom,
        output oChange,
        output oTick
    );
endinterface
`default_nettype wire

// File: rtl/bsk_com_filter.sv
`default_nettype none
// ============================================================================
//  Module      : bsk_com_filter
//  Description : Synchronises active-low command lines and debounces each one
//                with a saturating integrator with hysteresis.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsk_com_filter #(
    parameter int WIDTH      = 16,
    parameter int SAMPLE_DIV = 8,
    parameter int FILT_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  iRes,
    bsk_com_filter_if.slave       bus
);

    localparam int c_CW = $clog2(FILT_LEN + 1);
    localparam int c_PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(SAMPLE_DIV - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FILT_LEN);

    logic [c_PW-1:0]  r_presc;
    logic [c_PW-1:0]  w_prescNext;
    logic             r_tick;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_com;
    logic [WIDTH-1:0] w_comNext;
    logic             r_change;

    assign w_prescNext = (r_presc == c_PMAX) ? '0 : r_presc + 1'b1;

    // Tick is registered from the next prescaler value so it is low in reset
    always_ff @(posedge clk) begin
        if (iRes) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_prescNext;
            r_tick  <= (w_prescNext == c_PMAX);
        end
    end

    always_ff @(posedge clk) begin
        if (iRes) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~bus.iComRaw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [c_CW-1:0] r_cnt;
        logic [c_CW-1:0] w_cntNext;
        logic            w_bitNext;

        always_comb begin
            w_cntNext = r_cnt;
            if (!bus.iBl) begin
                w_cntNext = '0;
            end else if (r_tick) begin
                if (r_sync2[i] && (r_cnt != c_FULL)) begin
                    w_cntNext = r_cnt + 1'b1;
                end else if (!r_sync2[i] && (r_cnt != '0)) begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end
        end

        // Output only moves at the rails of the integrator, giving hysteresis
        always_comb begin
            w_bitNext = r_com[i];
            if (!bus.iBl) begin
                w_bitNext = 1'b0;
            end else if (w_cntNext == c_FULL) begin
                w_bitNext = 1'b1;
            end else if (w_cntNext == '0) begin
                w_bitNext = 1'b0;
            end
        end

        assign w_comNext[i] = w_bitNext;

        always_ff @(posedge clk) begin
            if (iRes) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cntNext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iRes) begin
            r_com    <= '0;
            r_change <= 1'b0;
        end else begin
            r_com    <= w_comNext;
            r_change <= |(w_comNext ^ r_com);
        end
    end

    assign bus.oCom    = r_com;
    assign bus.oChange = r_change;
    assign bus.oTick   = r_tick;

endmodule
`default_nettype wire
